// File: rtl/commit_trace_monitor_if.sv
// Retire-side and host-side signals of the commit trace monitor.
// master = core/host harness, slave = monitor.
interface commit_trace_monitor_if #(
   parameter int XLEN  = 64,
   parameter int DEPTH = 16
);
   logic [XLEN-1:0]          commit_pc;
   logic                     commit_stall;
   logic                     commit_ebreak;
   logic                     clr;
   logic                     trace_valid;
   logic                     trace_ready;
   logic [XLEN-1:0]          trace_pc;
   logic [$clog2(DEPTH):0]   fifo_level;
   logic                     overflow;
   logic [31:0]              drop_cnt;
   logic [XLEN-1:0]          retired_cnt;
   logic [XLEN-1:0]          cycle_cnt;
   logic                     halted;
   logic [XLEN-1:0]          halt_pc;

   modport master (
      output commit_pc, commit_stall, commit_ebreak, clr, trace_ready,
      input  trace_valid, trace_pc, fifo_level, overflow, drop_cnt,
             retired_cnt, cycle_cnt, halted, halt_pc
   );

   modport slave (
      input  commit_pc, commit_stall, commit_ebreak, clr, trace_ready,
      output trace_valid, trace_pc, fifo_level, overflow, drop_cnt,
             retired_cnt, cycle_cnt, halted, halt_pc
   );
endinterface

// File: rtl/commit_trace_monitor.sv
// Counts retirements/cycles, queues retired PCs for a host reader and
// turns ebreak into a halt after the pipeline drains.
module commit_trace_monitor #(
   parameter int XLEN         = 64,
   parameter int DEPTH        = 16,
   parameter int DRAIN_CYCLES = 3
) (
   input logic                   sys_clk,
   input logic                   sys_rst,
   commit_trace_monitor_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int DW = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t          state_q;
   logic [DW-1:0]   drain_q;
   logic            halted_q;
   logic [XLEN-1:0] halt_pc_q;

   logic [XLEN-1:0] mem [DEPTH];
   logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [LW-1:0]   level_q, level_d;
   logic [XLEN-1:0] retired_q, retired_d, cycle_q, cycle_d, last_pc_q, last_pc_d;
   logic [31:0]     drop_q, drop_d;
   logic            ovf_q, ovf_d;

   logic retire, push, pop, full, wr_en, drop;

   assign retire = !bus.commit_stall && (state_q != HALTED);
   assign push   = retire && !bus.clr;
   assign pop    = (level_q != '0) && bus.trace_ready && !bus.clr;
   assign full   = (level_q == LW'(DEPTH));
   // a full FIFO still accepts a push when the head leaves in the same cycle
   assign wr_en  = push && (!full || pop);
   assign drop   = push && full && !pop;

   always_comb begin
      wr_d      = wr_q;
      rd_d      = rd_q;
      level_d   = level_q;
      retired_d = retired_q;
      cycle_d   = cycle_q;
      last_pc_d = last_pc_q;
      drop_d    = drop_q;
      ovf_d     = ovf_q;
      if (bus.clr) begin
         wr_d      = '0;
         rd_d      = '0;
         level_d   = '0;
         retired_d = '0;
         cycle_d   = '0;
         drop_d    = '0;
         ovf_d     = 1'b0;
      end else begin
         if (state_q != HALTED) cycle_d = cycle_q + XLEN'(1);
         if (push) begin
            retired_d = retired_q + XLEN'(1);
            last_pc_d = bus.commit_pc;
         end
         if (wr_en) wr_d = wr_q + AW'(1);
         if (pop)   rd_d = rd_q + AW'(1);
         case ({wr_en, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
         if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + 32'd1;
         end
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         wr_q      <= '0;
         rd_q      <= '0;
         level_q   <= '0;
         retired_q <= '0;
         cycle_q   <= '0;
         last_pc_q <= '0;
         drop_q    <= '0;
         ovf_q     <= 1'b0;
      end else begin
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         level_q   <= level_d;
         retired_q <= retired_d;
         cycle_q   <= cycle_d;
         last_pc_q <= last_pc_d;
         drop_q    <= drop_d;
         ovf_q     <= ovf_d;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (wr_en) mem[wr_q] <= bus.commit_pc;
   end

   // halt_pc picks up a retirement landing in the final drain cycle
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q   <= RUN;
         drain_q   <= '0;
         halted_q  <= 1'b0;
         halt_pc_q <= '0;
      end else begin
         case (state_q)
            RUN: begin
               if (bus.commit_ebreak) begin
                  state_q <= DRAIN;
                  drain_q <= DW'(DRAIN_CYCLES);
               end
            end
            DRAIN: begin
               drain_q <= drain_q - DW'(1);
               if (drain_q == DW'(1)) begin
                  state_q   <= HALTED;
                  halted_q  <= 1'b1;
                  halt_pc_q <= push ? bus.commit_pc : last_pc_q;
               end
            end
            default: state_q <= HALTED;
         endcase
      end
   end

   assign bus.trace_valid = (level_q != '0);
   assign bus.trace_pc    = (level_q != '0) ? mem[rd_q] : '0;
   assign bus.fifo_level  = level_q;
   assign bus.overflow    = ovf_q;
   assign bus.drop_cnt    = drop_q;
   assign bus.retired_cnt = retired_q;
   assign bus.cycle_cnt   = cycle_q;
   assign bus.halted      = halted_q;
   assign bus.halt_pc     = halt_pc_q;
endmodule
